sdram_port_arbiter: RTL
=======================

Name: sdram_port_arbiter

Overview:
- Parametrised SDRAM request arbiter. Replaces the per-mode combinational SDRAM mux in the top-level core with a registered, N-port arbiter.
- Sits between the processing cores (load, mix, pitch, record, play, and future cores) and the SDRAM bus adapter.
- Supports round-robin or fixed-priority selection, a per-port enable mask, grant locking for a full transaction, and a watchdog timeout.

Parameters:
- NUM_PORTS, 5: number of client ports (2..16).
- ADDR_W, 23: SDRAM word-address width.
- DATA_W, 32: SDRAM data width.
- TIMEOUT, 4096: maximum cycles a granted transaction may wait for sdram_finished (>= 4).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous reset, active-high.
- port_enable  in  NUM_PORTS  per-port arbitration mask (1 = may be granted).
- arb_mode  in  1  0 = round-robin, 1 = fixed priority (lowest index wins).
- req_read  in  NUM_PORTS  per-port read request, held by the client until its finished pulse.
- req_write  in  NUM_PORTS  per-port write request, held by the client until its finished pulse.
- req_addr  in  NUM_PORTS*ADDR_W  flattened addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
- req_writedata  in  NUM_PORTS*DATA_W  flattened write data; port k occupies bits [k*DATA_W +: DATA_W].
- req_readdata  out  DATA_W  registered read data, shared by all ports, valid when that port's req_finished bit is 1.
- req_finished  out  NUM_PORTS  one-hot, one-cycle completion pulse.
- grant  out  NUM_PORTS  one-hot current owner; 0 when idle.
- busy  out  1  high when the state is ISSUE or DONE.
- timeout_err  out  1  sticky watchdog flag.
- sdram_read  out  1  to the SDRAM bus adapter.
- sdram_write  out  1  to the SDRAM bus adapter.
- sdram_addr  out  ADDR_W  to the SDRAM bus adapter.
- sdram_writedata  out  DATA_W  to the SDRAM bus adapter.
- sdram_readdata  in  DATA_W  from the SDRAM bus adapter.
- sdram_finished  in  1  one-cycle completion pulse from the SDRAM bus adapter.

Behaviour:
- Reset (async, i_rst = 1): every output goes to 0. State = IDLE. Round-robin pointer last = NUM_PORTS-1, so port 0 wins first. Watchdog counter = 0. timeout_err = 0.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, ISSUE, DONE.
- IDLE:
  - cand = (req_read | req_write) & port_enable.
  - cand == 0: stay in IDLE.
  - cand != 0: select winner g.
    - Round-robin: first set bit searching from last+1 upward, wrapping at NUM_PORTS.
    - Fixed: lowest set index.
  - On the edge: latch op, addr and writedata of port g; set grant = onehot(g); last = g; counter = 0; go to ISSUE.
  - If req_write[g] and req_read[g] are both 1, write wins.
- ISSUE:
  - Drive sdram_read or sdram_write = latched op, plus latched sdram_addr and sdram_writedata. These hold constant for the whole state.
  - Client inputs are ignored. A withdrawn request or a cleared port_enable does not abort the transaction.
  - sdram_finished = 1: register req_readdata = sdram_readdata (0 for writes); go to DONE.
  - Otherwise counter increments. When counter == TIMEOUT-1 with no finish: set req_readdata = 0 and timeout_err = 1; go to DONE.
- DONE (exactly 1 cycle):
  - sdram_read = sdram_write = 0.
  - req_finished = grant; grant stays asserted this cycle.
  - Next state is IDLE with grant = 0.
  - No arbitration happens in DONE, so a client's stale request is not re-granted.
- Latency:
  - Request sampled in IDLE at edge N: sdram strobe is high in cycle N+1.
  - sdram_finished seen at edge M: req_finished pulses in cycle M+1.
  - The next grant is earliest at edge M+2.
  - Back-to-back throughput = SDRAM latency + 2 cycles.
- sdram_finished received in IDLE or DONE is ignored.
- Switching arb_mode takes effect at the next IDLE decision. The round-robin pointer is still updated in fixed mode.
- timeout_err is cleared only by i_rst.

Test Plan:
- Port 2 read, addr 0x000123; bench asserts sdram_finished with readdata 0xDEADBEEF 3 cycles after sdram_read rises -> sdram_read = 1 and sdram_addr = 0x000123 one cycle after request; req_finished = 5'b00100 with req_readdata = 0xDEADBEEF for exactly 1 cycle; grant = 0 afterwards.
- arb_mode = 0; ports 0, 1, 3 request continuously and re-request after each finish -> grant sequence 0, 1, 3, 0, 1, 3; port 3 never starves.
- arb_mode = 1; same stimulus -> port 0 wins every arbitration; ports 1 and 3 are never granted while port 0 requests.
- port_enable = 5'b11101; ports 1 and 2 request -> only port 2 granted; enabling bit 1 mid-transaction has no effect until the next IDLE.
- TIMEOUT = 16; port 4 write, sdram_finished never arrives -> sdram_write drops after 16 ISSUE cycles; req_finished[4] pulses; req_readdata = 0; timeout_err = 1 and stays 1.
- Port 1 and port 0 both assert read and write; i_rst pulsed mid-ISSUE -> write issued for the granted port; on reset all outputs are 0 asynchronously, and after release port 0 is granted first.

Source files
------------

// File: rtl/sdram_port_arbiter_if.sv
// Signal bundle between client cores / SDRAM bus adapter and the N-port arbiter.
// slave is the arbiter's view; master is the environment (clients plus adapter).
interface sdram_port_arbiter_if #(
    parameter int NUM_PORTS = 5,
    parameter int ADDR_W    = 23,
    parameter int DATA_W    = 32
);
    logic [NUM_PORTS-1:0]        port_enable;
    logic                        arb_mode;
    logic [NUM_PORTS-1:0]        req_read;
    logic [NUM_PORTS-1:0]        req_write;
    logic [NUM_PORTS*ADDR_W-1:0] req_addr;
    logic [NUM_PORTS*DATA_W-1:0] req_writedata;
    logic [DATA_W-1:0]           req_readdata;
    logic [NUM_PORTS-1:0]        req_finished;
    logic [NUM_PORTS-1:0]        grant;
    logic                        busy;
    logic                        timeout_err;
    logic                        sdram_read;
    logic                        sdram_write;
    logic [ADDR_W-1:0]           sdram_addr;
    logic [DATA_W-1:0]           sdram_writedata;
    logic [DATA_W-1:0]           sdram_readdata;
    logic                        sdram_finished;

    modport slave (
        input  port_enable, arb_mode, req_read, req_write, req_addr, req_writedata,
               sdram_readdata, sdram_finished,
        output req_readdata, req_finished, grant, busy, timeout_err,
               sdram_read, sdram_write, sdram_addr, sdram_writedata
    );

    modport master (
        output port_enable, arb_mode, req_read, req_write, req_addr, req_writedata,
               sdram_readdata, sdram_finished,
        input  req_readdata, req_finished, grant, busy, timeout_err,
               sdram_read, sdram_write, sdram_addr, sdram_writedata
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Registered N-port SDRAM request arbiter: round-robin or fixed priority, grant held
// for a whole transaction, sticky watchdog when the adapter never finishes.
module sdram_port_arbiter #(
    parameter int NUM_PORTS = 5,
    parameter int ADDR_W    = 23,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 4096
) (
    input  logic                i_clk,
    input  logic                i_rst,
    sdram_port_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [NUM_PORTS-1:0] fin_q, fin_d;
    logic                 rd_q, rd_d;
    logic                 wr_q, wr_d;
    logic                 busy_q, busy_d;
    logic                 terr_q, terr_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;

    logic [NUM_PORTS-1:0] cand;
    logic [IDX_W-1:0]     rr_idx;
    logic [IDX_W-1:0]     fx_idx;
    logic [IDX_W-1:0]     win;
    logic                 rr_found;
    logic [ADDR_W-1:0]    addr_arr  [NUM_PORTS];
    logic [DATA_W-1:0]    wdata_arr [NUM_PORTS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
            assign addr_arr[gi]  = bus.req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_arr[gi] = bus.req_writedata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    assign cand = (bus.req_read | bus.req_write) & bus.port_enable;

    // Both candidate winners are always computed; arb_mode only picks one.
    always_comb begin : winner
        int pos;
        pos      = 0;
        rr_found = 1'b0;
        rr_idx   = '0;
        fx_idx   = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            pos = int'(last_q) + i;
            if (pos >= NUM_PORTS) pos = pos - NUM_PORTS;
            if (!rr_found && cand[IDX_W'(pos)]) begin
                rr_found = 1'b1;
                rr_idx   = IDX_W'(pos);
            end
        end
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (cand[IDX_W'(i)]) fx_idx = IDX_W'(i);
        end
        win = bus.arb_mode ? fx_idx : rr_idx;
    end

    always_comb begin : next_state
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        fin_d   = '0;
        rd_d    = rd_q;
        wr_d    = wr_q;
        busy_d  = busy_q;
        terr_d  = terr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (|cand) begin
                    state_d = ISSUE;
                    grant_d = NUM_PORTS'(1) << win;
                    last_d  = win;
                    cnt_d   = '0;
                    // Write takes precedence when a client raises both strobes.
                    wr_d    = bus.req_write[win];
                    rd_d    = ~bus.req_write[win];
                    addr_d  = addr_arr[win];
                    wdata_d = wdata_arr[win];
                    busy_d  = 1'b1;
                end
            end
            ISSUE: begin
                if (bus.sdram_finished) begin
                    state_d = DONE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    rdata_d = wr_q ? '0 : bus.sdram_readdata;
                    fin_d   = grant_q;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    rdata_d = '0;
                    terr_d  = 1'b1;
                    fin_d   = grant_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            last_q  <= IDX_W'(NUM_PORTS - 1);
            cnt_q   <= '0;
            grant_q <= '0;
            fin_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            terr_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            fin_q   <= fin_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            terr_q  <= terr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.grant           = grant_q;
    assign bus.req_finished    = fin_q;
    assign bus.req_readdata    = rdata_q;
    assign bus.busy            = busy_q;
    assign bus.timeout_err     = terr_q;
    assign bus.sdram_read      = rd_q;
    assign bus.sdram_write     = wr_q;
    assign bus.sdram_addr      = addr_q;
    assign bus.sdram_writedata = wdata_q;
endmodule
